// File: rtl/acq_match_gen_pkg.sv
// Shared acquisition-correlator constants and the front-end FSM state type.
package acq_match_gen_pkg;

    localparam int unsigned SEG_LEN  = 341;
    localparam int unsigned WORD_W   = 31;
    localparam int unsigned WORDS    = 11;
    localparam int unsigned TREE_LAT = 2;
    localparam int unsigned SUM_W    = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILL,
        RUN
    } acq_state_t;

endpackage

// File: rtl/acq_match_gen.sv
// Correlator front end: code segment + sample sign shift register driving the
// external adder tree, and conversion of the tree count into a tagged signed value.
module acq_match_gen
    import acq_match_gen_pkg::*;
#(
    parameter int unsigned CORR_W = 10,
    parameter int unsigned IDX_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               code_wr,
    input  logic [WORD_W-1:0]  code_word,
    input  logic               sample_valid,
    input  logic               sample_sign,
    output logic [SEG_LEN-1:0] tree_in,
    input  logic [SUM_W-1:0]   tree_out,
    output logic               corr_valid,
    output logic [CORR_W-1:0]  corr_out,
    output logic [IDX_W-1:0]   corr_idx,
    output logic               busy
);

    acq_state_t         state, state_nxt;
    logic [3:0]         word_cnt;
    logic [8:0]         fill_cnt;
    logic [SEG_LEN-1:0] code_reg;
    logic [SEG_LEN-1:0] sample_sr;
    logic [SEG_LEN-1:0] sr_next;
    logic [TREE_LAT:0]  iss_pipe;
    logic [IDX_W-1:0]   idx_pipe [TREE_LAT+1];
    logic [IDX_W-1:0]   run_idx;
    logic [IDX_W-1:0]   iss_idx;
    logic               accept;
    logic               last_word;
    logic               fill_done;
    logic               issue;

    always_comb begin
        accept    = sample_valid && !abort && (state == FILL || state == RUN);
        last_word = code_wr && (state == LOAD) && (word_cnt == 4'(WORDS - 1));
        fill_done = accept && (state == FILL) && (fill_cnt == 9'(SEG_LEN - 1));
        issue     = accept && (state == RUN || fill_done);
        // The sample that completes the fill is the first RUN issue and takes index 0.
        iss_idx   = (state == RUN) ? run_idx : '0;
        sr_next   = {sample_sr[SEG_LEN-2:0], sample_sign};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)     state_nxt = LOAD;
                LOAD:    if (last_word) state_nxt = FILL;
                FILL:    if (fill_done) state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt   <= '0;
            fill_cnt   <= '0;
            code_reg   <= '0;
            sample_sr  <= '0;
            tree_in    <= '0;
            iss_pipe   <= '0;
            run_idx    <= '0;
            corr_valid <= 1'b0;
            corr_out   <= '0;
            corr_idx   <= '0;
            for (int unsigned i = 0; i <= TREE_LAT; i++) begin
                idx_pipe[i] <= '0;
            end
        end else begin
            iss_pipe    <= abort ? '0 : {iss_pipe[TREE_LAT-1:0], issue};
            idx_pipe[0] <= iss_idx;
            for (int unsigned i = 1; i <= TREE_LAT; i++) begin
                idx_pipe[i] <= idx_pipe[i-1];
            end

            // tree_out lines up with the last pipeline stage; register it here.
            corr_valid <= iss_pipe[TREE_LAT] && !abort;
            if (iss_pipe[TREE_LAT] && !abort) begin
                corr_out <= CORR_W'({1'b0, tree_out, 1'b0}) - CORR_W'(SEG_LEN);
                corr_idx <= idx_pipe[TREE_LAT];
            end

            if (state == IDLE && start && !abort) begin
                word_cnt <= '0;
            end

            if (state == LOAD && code_wr && !abort) begin
                for (int unsigned k = 0; k < WORDS; k++) begin
                    if (word_cnt == 4'(k)) begin
                        code_reg[k*WORD_W +: WORD_W] <= code_word;
                    end
                end
                word_cnt <= word_cnt + 4'd1;
                if (last_word) begin
                    fill_cnt  <= '0;
                    sample_sr <= '0;
                end
            end

            if (accept) begin
                sample_sr <= sr_next;
                if (state == FILL) begin
                    fill_cnt <= fill_cnt + 9'd1;
                end
            end

            if (issue) begin
                tree_in <= ~(sr_next ^ code_reg);
                run_idx <= iss_idx + 1'b1;
            end
        end
    end

endmodule
